// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO: circular buffer with registered decoder outputs and ROB flush.
// Optional IQ_BYPASS_EN forwards a fetched instruction straight to the outputs when the queue is empty.
module instr_queue #(
    parameter int QueueDepth = 16,
    parameter int PtrLength  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_valid_from_fetcher,
    input  logic [31:0] instr_from_fetcher,
    input  logic [31:0] pc_from_fetcher,
    input  logic        is_stall_from_rf,
    input  logic        is_exception_from_rob,
    output logic        is_full_to_fetcher,
    output logic        is_empty_to_decoder,
    output logic [31:0] instr_to_decoder,
    output logic [31:0] pc_to_decoder
);
    localparam int CntW = PtrLength + 2;
    localparam logic [CntW-1:0] FULL_CNT = CntW'(QueueDepth);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t                 mem [QueueDepth];
    logic [PtrLength:0]     head, tail;
    logic [CntW-1:0]        count;
    logic                   bypass, do_push, do_pop;

`ifdef IQ_BYPASS_EN
    assign bypass = is_valid_from_fetcher && !is_stall_from_rf && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction goes to the outputs only, never into storage.
    assign do_push = is_valid_from_fetcher && (count != FULL_CNT) && !bypass;
    assign do_pop  = !is_stall_from_rf && (count != '0);

    assign is_full_to_fetcher = (count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (!rst && !is_exception_from_rob && do_push)
            mem[tail] <= '{instr: instr_from_fetcher, pc: pc_from_fetcher};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            is_empty_to_decoder <= 1'b1;
            instr_to_decoder    <= '0;
            pc_to_decoder       <= '0;
        end else if (is_exception_from_rob) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            is_empty_to_decoder <= 1'b1;
        end else begin
            if (do_push)
                tail <= tail + 1'b1;
            if (do_pop) begin
                instr_to_decoder    <= mem[head].instr;
                pc_to_decoder       <= mem[head].pc;
                head                <= head + 1'b1;
                is_empty_to_decoder <= 1'b0;
            end else if (bypass) begin
                instr_to_decoder    <= instr_from_fetcher;
                pc_to_decoder       <= pc_from_fetcher;
                is_empty_to_decoder <= 1'b0;
            end else if (!is_stall_from_rf) begin
                is_empty_to_decoder <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter QueueDepth, default 16, means the number of instruction entries; it SHALL be a power of two, at least 2.
REQ-002 Parameter PtrLength, default 3, means the pointer MSB index, so pointers are PtrLength+1 bits wide; it SHALL equal log2(QueueDepth)-1.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 is_valid_from_fetcher  in  1  a fetched instruction is presented this cycle.
REQ-006 instr_from_fetcher  in  32  the instruction word.
REQ-007 pc_from_fetcher  in  32  the instruction PC.
REQ-008 is_stall_from_rf  in  1  the register file cannot accept an instruction this cycle.
REQ-009 is_exception_from_rob  in  1  the ROB requests a flush after a mispredict or exception.
REQ-010 is_full_to_fetcher  out  1  the queue holds QueueDepth entries; this output is combinational from the registered count.
REQ-011 is_empty_to_decoder  out  1  registered; 1 means the decoder outputs carry no instruction.
REQ-012 instr_to_decoder  out  32  registered instruction word.
REQ-013 pc_to_decoder  out  32  registered instruction PC.

Function
REQ-014 Storage SHALL be a circular buffer with head pointer, tail pointer, and a count of 0..QueueDepth; pointers SHALL wrap from QueueDepth-1 to 0.
REQ-015 Push: on an edge with is_valid_from_fetcher=1 and count<QueueDepth, {instr, pc} SHALL be written at tail and tail SHALL increment.
REQ-016 A push presented when count==QueueDepth SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-017 Pop: on an edge with is_stall_from_rf=0 and count>0, the head entry SHALL be loaded into the output registers, head SHALL increment, and is_empty_to_decoder SHALL become 0.
REQ-018 On an edge with is_stall_from_rf=0 and count==0, is_empty_to_decoder SHALL become 1; instr_to_decoder and pc_to_decoder SHALL hold their values.
REQ-019 On an edge with is_stall_from_rf=1, the output registers and head SHALL hold; pushes SHALL still be accepted.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push only SHALL add 1; pop only SHALL subtract 1.
REQ-021 Latency without bypass: an instruction pushed at edge N into an empty queue SHALL appear at the outputs after edge N+1 if unstalled.
REQ-022 Order SHALL be strict FIFO; no entry SHALL be duplicated or lost except by flush or by a dropped push (REQ-016).
REQ-023 Flush: on an edge with is_exception_from_rob=1, the block SHALL clear head, tail and count to 0 and set is_empty_to_decoder to 1, and the fetcher input that cycle SHALL be discarded.
REQ-024 Flush SHALL override push, pop and stall in the same cycle.
REQ-025 is_full_to_fetcher SHALL equal (count==QueueDepth).

Reset
REQ-026 While rst=1 at an edge, head, tail and count SHALL be cleared to 0, is_empty_to_decoder set to 1, and instr_to_decoder and pc_to_decoder set to 0.
REQ-027 Reset SHALL take priority over flush, push and pop; mid-operation contents SHALL be discarded.
REQ-028 Storage array contents need not be reset.
REQ-029 is_full_to_fetcher SHALL read 0 in the cycle after reset.

Configuration
REQ-030 Macro IQ_BYPASS_EN: when defined, an edge with count==0, is_valid_from_fetcher=1, is_stall_from_rf=0 and no flush SHALL load the fetcher input directly into the output registers; that entry SHALL not be written to storage, the count SHALL stay 0, and latency SHALL be 0 extra edges.
REQ-031 When IQ_BYPASS_EN is undefined, no bypass path SHALL exist and REQ-021 latency SHALL apply.

Verification
REQ-032 Reset: rst=1 for 2 cycles -> is_empty_to_decoder=1, is_full_to_fetcher=0, instr_to_decoder=0, pc_to_decoder=0.
REQ-033 Fill: with stall=1, push 16 instructions (pc 0x00..0x3C) -> is_full_to_fetcher=1; a 17th push (pc 0x40) is dropped; releasing stall yields pcs 0x00..0x3C in order, then is_empty_to_decoder=1.
REQ-034 Wrap: run 40 unstalled push/pop pairs with pc incrementing by 4 -> the output pc sequence is exact, count stays at most 1, and the pointers wrap at least twice.
REQ-035 Stall hold: with 3 entries queued (pc 0x100, 0x104, 0x108), assert stall for 5 cycles after 0x100 is output -> pc_to_decoder holds 0x100; 0x104 follows one edge after release.
REQ-036 Flush: with 8 entries queued, assert exception together with a push of pc 0x200 -> count=0 and is_empty_to_decoder=1, and 0x200 never appears at the outputs.
REQ-037 Bypass: push pc 0x80 into an empty unstalled queue at edge N -> with IQ_BYPASS_EN, pc_to_decoder=0x80 after edge N; without it, after edge N+1.
